// File: rtl/ysyx_2022040010_mul_ctrl_if.sv
// ysyx_2022040010_mul_ctrl_if: decode, multiplier and writeback signals of the RV64M multiply controller
interface ysyx_2022040010_mul_ctrl_if;
  logic flush;
  logic in_valid;
  logic in_ready;
  logic [2:0] in_op;
  logic [63:0] in_rs1;
  logic [63:0] in_rs2;
  logic [4:0] in_rd;
  logic mul_ina_s;
  logic [63:0] mul_ina;
  logic mul_inb_s;
  logic [63:0] mul_inb;
  logic [2:0] mul_sel_hilo;
  logic [63:0] mul_result;
  logic mul_over;
  logic out_valid;
  logic out_ready;
  logic [4:0] out_rd;
  logic [63:0] out_data;
  logic busy;
  modport master(
    output flush, in_valid, in_op, in_rs1, in_rs2, in_rd, mul_result, mul_over, out_ready,
    input in_ready, mul_ina_s, mul_ina, mul_inb_s, mul_inb, mul_sel_hilo, out_valid, out_rd, out_data, busy
  );
  modport slave(
    input flush, in_valid, in_op, in_rs1, in_rs2, in_rd, mul_result, mul_over, out_ready,
    output in_ready, mul_ina_s, mul_ina, mul_inb_s, mul_inb, mul_sel_hilo, out_valid, out_rd, out_data, busy
  );
endinterface

// File: rtl/ysyx_2022040010_mul_ctrl.sv
// ysyx_2022040010_mul_ctrl: EX-stage issue/collect controller holding operands on a multicycle multiplier
// Define MUL_CTRL_FUSE_EN to add a one-entry result cache that short-circuits a repeated {op,rs1,rs2}.
module ysyx_2022040010_mul_ctrl #(
  parameter int LATENCY = 2
) (
  input logic clk,
  input logic ret,
  ysyx_2022040010_mul_ctrl_if.slave b
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t r_state;
  logic [3:0] r_cnt;
  logic r_out_valid;
  logic r_sa;
  logic r_sb;
  logic [2:0] r_sel;
  logic [63:0] r_a;
  logic [63:0] r_b;
  logic [63:0] r_data;
  logic [4:0] r_rd;
  logic w_ready;
  logic w_accept;
  logic w_hit;
  logic w_sa;
  logic w_sb;
  logic [2:0] w_sel;
  logic [63:0] w_hit_data;
  always_comb begin
    w_ready = !ret && !b.flush && (r_state == IDLE || (r_state == DONE && b.out_ready));
    w_accept = b.in_valid && w_ready;
    w_sa = b.in_op == 3'd1 || b.in_op == 3'd2;
    w_sb = b.in_op == 3'd1;
    w_sel = (b.in_op != 3'd0 && b.in_op < 3'd4) ? 3'b010 : (b.in_op == 3'd4) ? 3'b001 : 3'b100;
  end
`ifdef MUL_CTRL_FUSE_EN
  logic r_c_v;
  logic [2:0] r_c_op;
  logic [2:0] r_k_op;
  logic [63:0] r_c_a;
  logic [63:0] r_c_b;
  logic [63:0] r_c_d;
  logic [63:0] r_k_a;
  logic [63:0] r_k_b;
  assign w_hit = r_c_v && b.in_op == r_c_op && b.in_rs1 == r_c_a && b.in_rs2 == r_c_b;
  assign w_hit_data = r_c_d;
  // r_k_* remembers the key of the op in flight so the entry is written only once its result is taken
  always_ff @(posedge clk) begin
    if (ret || b.flush) begin
      r_c_v <= 1'b0;
    end else begin
      if (r_state == DONE && b.out_ready) begin
        r_c_v <= 1'b1;
        r_c_op <= r_k_op;
        r_c_a <= r_k_a;
        r_c_b <= r_k_b;
        r_c_d <= r_data;
      end
      if (w_accept) begin
        r_k_op <= b.in_op;
        r_k_a <= b.in_rs1;
        r_k_b <= b.in_rs2;
      end
    end
  end
`else
  assign w_hit = 1'b0;
  assign w_hit_data = '0;
`endif
  always_ff @(posedge clk) begin
    if (ret) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_out_valid <= 1'b0;
      r_data <= '0;
      r_rd <= '0;
      r_a <= '0;
      r_b <= '0;
      r_sa <= 1'b0;
      r_sb <= 1'b0;
      r_sel <= '0;
    end else if (b.flush) begin
      r_state <= IDLE;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_rd <= b.in_rd;
      r_state <= w_hit ? DONE : CALC;
      r_out_valid <= w_hit;
      r_cnt <= 4'(LATENCY - 1);
      if (w_hit) begin
        r_data <= w_hit_data;
      end else begin
        r_a <= b.in_rs1;
        r_b <= b.in_rs2;
        r_sa <= w_sa;
        r_sb <= w_sb;
        r_sel <= w_sel;
      end
    end else if (r_state == CALC && r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end else if (r_state == CALC) begin
      r_data <= b.mul_result;
      r_state <= DONE;
      r_out_valid <= 1'b1;
    end else if (r_state == DONE && b.out_ready) begin
      r_state <= IDLE;
      r_out_valid <= 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (!ret && !b.flush && r_state == CALC && r_cnt == 4'd0)
      assert (b.mul_over) else $error("mul_ctrl: multiplier result not valid at capture");
  end
  assign b.in_ready = w_ready;
  assign b.mul_ina = r_a;
  assign b.mul_inb = r_b;
  assign b.mul_ina_s = r_sa;
  assign b.mul_inb_s = r_sb;
  assign b.mul_sel_hilo = r_sel;
  assign b.out_valid = r_out_valid;
  assign b.out_data = r_data;
  assign b.out_rd = r_rd;
  assign b.busy = r_state != IDLE;
endmodule
